// File: rtl/tri_raster_stream.sv
// Triangle rasterizer: latches three vertices, scans the clamped bounding box with
// incremental edge functions and streams frame-buffer writes. Optional macro: BBOX_FILL_EN.
module tri_raster_stream #(
  parameter int FB_W    = 399,
  parameter int FB_H    = 300,
  parameter int XW      = 9,
  parameter int YW      = 9,
  parameter int COLOR_W = 9,
  parameter int ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [XW-1:0]      x0,
  input  logic [XW-1:0]      x1,
  input  logic [XW-1:0]      x2,
  input  logic [YW-1:0]      y0,
  input  logic [YW-1:0]      y1,
  input  logic [YW-1:0]      y2,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_data
);

  localparam int CW = (XW > YW) ? XW : YW;
  localparam int EW = 2 * CW + 3;
  localparam logic [XW-1:0]     X_LAST = XW'(FB_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(FB_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_W);
`ifdef BBOX_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef logic signed [EW-1:0] edge_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_SCAN, S_DONE} state_t;

  state_t              state;
  logic [XW-1:0]       vx [3];
  logic [YW-1:0]       vy [3];
  logic [COLOR_W-1:0]  col;
  logic [XW-1:0]       xmin, xmax, cur_x;
  logic [YW-1:0]       ymin, ymax, cur_y;
  logic                bbox_empty, area_neg, area_zero;
  edge_t               a [3], b [3], e [3], row_e [3];
  logic [ADDR_W-1:0]   row_addr;

  edge_t               sx [3], sy [3], a_set [3], b_set [3], a_eff [3], b_eff [3];
  edge_t               e_init [3], e_next [3];
  edge_t               area_set;
  logic [XW-1:0]       xmin_raw, xmax_raw;
  logic [YW-1:0]       ymin_raw, ymax_raw;
  logic [ADDR_W-1:0]   base_addr, addr_next;
  logic [COLOR_W-1:0]  init_data, next_data;
  logic                init_inside, next_inside, last_x, last_y, advance;

  // NOTE: every combinational output gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    last_x   = (cur_x == xmax);
    last_y   = (cur_y == ymax);
    advance  = (state == S_SCAN) && (!pix_valid || pix_ready);
    xmin_raw = vx[0];
    xmax_raw = vx[0];
    ymin_raw = vy[0];
    ymax_raw = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xmin_raw) xmin_raw = vx[i];
      if (vx[i] > xmax_raw) xmax_raw = vx[i];
      if (vy[i] < ymin_raw) ymin_raw = vy[i];
      if (vy[i] > ymax_raw) ymax_raw = vy[i];
    end
    for (int i = 0; i < 3; i++) begin
      sx[i] = edge_t'(vx[i]);
      sy[i] = edge_t'(vy[i]);
    end
    // Edge i runs from vertex i to vertex i+1; the sign of E tells which side a point lies on.
    for (int i = 0; i < 3; i++) begin
      a_set[i]  = sy[(i + 1) % 3] - sy[i];
      b_set[i]  = sx[i] - sx[(i + 1) % 3];
      a_eff[i]  = area_neg ? -a[i] : a[i];
      b_eff[i]  = area_neg ? -b[i] : b[i];
      e_init[i] = a_eff[i] * (edge_t'(xmin) - sx[i]) + b_eff[i] * (edge_t'(ymin) - sy[i]);
      e_next[i] = last_x ? row_e[i] + b[i] : e[i] + a[i];
    end
    area_set    = a_set[0] * (sx[2] - sx[0]) + b_set[0] * (sy[2] - sy[0]);
    init_inside = !e_init[0][EW-1] && !e_init[1][EW-1] && !e_init[2][EW-1];
    next_inside = !e_next[0][EW-1] && !e_next[1][EW-1] && !e_next[2][EW-1];
    init_data   = (FILL && !init_inside) ? '1 : col;
    next_data   = (FILL && !next_inside) ? '1 : col;
    base_addr   = ADDR_W'(ymin) * STRIDE + ADDR_W'(xmin);
    addr_next   = last_x ? row_addr + STRIDE : pix_addr + 1'b1;
  end

  // NOTE: the datapath registers carry no reset; the FSM always writes them before they are read.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          vx[0] <= x0;
          vx[1] <= x1;
          vx[2] <= x2;
          vy[0] <= y0;
          vy[1] <= y1;
          vy[2] <= y2;
          col   <= color;
        end
      end
      S_SETUP: begin
        for (int i = 0; i < 3; i++) begin
          a[i] <= a_set[i];
          b[i] <= b_set[i];
        end
        area_neg   <= area_set[EW-1];
        area_zero  <= (area_set == '0);
        xmin       <= xmin_raw;
        ymin       <= ymin_raw;
        xmax       <= (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
        ymax       <= (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;
        // Coordinates are unsigned, so only a minimum past the far edge can empty the box.
        bbox_empty <= (xmin_raw > X_LAST) || (ymin_raw > Y_LAST);
      end
      S_INIT: begin
        for (int i = 0; i < 3; i++) begin
          a[i]     <= a_eff[i];
          b[i]     <= b_eff[i];
          e[i]     <= e_init[i];
          row_e[i] <= e_init[i];
        end
        cur_x    <= xmin;
        cur_y    <= ymin;
        row_addr <= base_addr;
      end
      S_SCAN: begin
        if (advance) begin
          for (int i = 0; i < 3; i++) e[i] <= e_next[i];
          if (last_x) begin
            for (int i = 0; i < 3; i++) row_e[i] <= e_next[i];
            cur_x    <= xmin;
            cur_y    <= cur_y + 1'b1;
            row_addr <= addr_next;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_addr  <= '0;
      pix_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SETUP;
            busy  <= 1'b1;
          end
        end
        S_SETUP: state <= S_INIT;
        S_INIT: begin
          if (area_zero || bbox_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_SCAN;
            pix_valid <= FILL || init_inside;
            pix_addr  <= base_addr;
            pix_data  <= init_data;
          end
        end
        S_SCAN: begin
          if (advance) begin
            if (last_x && last_y) begin
              state     <= S_DONE;
              done      <= 1'b1;
              pix_valid <= 1'b0;
            end else begin
              pix_valid <= FILL || next_inside;
              pix_addr  <= addr_next;
              pix_data  <= next_data;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_stream.sv
// Directed bench for tri_raster_stream: vector table plus backpressure, mid-scan start
// and mid-scan reset sequences. Expectations follow BBOX_FILL_EN when it is defined.
`timescale 1ns/1ps
module tb_tri_raster_stream;
  localparam int FB_W = 399, FB_H = 300, XW = 9, YW = 9, COLOR_W = 9, ADDR_W = 17;
  localparam int FRAME = FB_W * FB_H;
`ifdef BBOX_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int color;
    int n, n_fill, n_col;
    int first, last, last_fill;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pix_ready = 1'b1;
  logic [XW-1:0] x0 = '0, x1 = '0, x2 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0, y2 = '0;
  logic [COLOR_W-1:0] color = '0;
  logic busy, done, pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [COLOR_W-1:0] pix_data;

  tri_raster_stream #(.FB_W(FB_W), .FB_H(FB_H), .XW(XW), .YW(YW), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2), .color(color),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr[$];
  int wr_data[$];
  int first_v = -1, done_c = -1, done_cnt = 0, start_cyc = 0;
  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      wr_addr.push_back(int'(pix_addr));
      wr_data.push_back(int'(pix_data));
    end
    if (pix_valid && first_v < 0) first_v = cyc;
    if (done) begin
      done_cnt++;
      if (done_c < 0) done_c = cyc;
    end
  end

  int n_run = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_run++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    first_v  = -1;
    done_c   = -1;
    done_cnt = 0;
  endtask

  task automatic start_tri(input vec_t v);
    @(posedge clk); #1;
    x0 = XW'(v.x0); y0 = YW'(v.y0);
    x1 = XW'(v.x1); y1 = YW'(v.y1);
    x2 = XW'(v.x2); y2 = YW'(v.y2);
    color = COLOR_W'(v.color);
    clear_mon();
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_col = 0, bad = 0;
    string nm = $sformatf("v%0d", idx);
    pix_ready = 1'b1;
    start_tri(v);
    wait_done(nm);
    check({nm, "_count"}, wr_addr.size(), FILL ? v.n_fill : v.n);
    for (int k = 0; k < wr_addr.size(); k++) begin
      if (wr_data[k] == v.color) n_col++;
      else if (wr_data[k] != 'h1FF) bad++;
      if (wr_addr[k] >= FRAME) bad++;
      if (k > 0 && wr_addr[k] <= wr_addr[k-1]) bad++;
    end
    check({nm, "_color_writes"}, n_col, v.n_col);
    check({nm, "_bad_writes"}, bad, 0);
    if (wr_addr.size() > 0) begin
      check({nm, "_first_addr"}, wr_addr[0], v.first);
      check({nm, "_last_addr"}, wr_addr[wr_addr.size()-1], FILL ? v.last_fill : v.last);
      check({nm, "_first_valid_lat"}, first_v - start_cyc, 3);
    end else begin
      check({nm, "_done_lat"}, done_c - start_cyc, 3);
    end
  endtask

  vec_t tbl[7];
  int exp_a[$];
  int exp_d[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 3, 0, 0, 3, 'h0A5, 10, 16, 10, 0, 1197, 1200};
    tbl[1] = '{0, 0, 0, 3, 3, 0, 'h0A5, 10, 16, 10, 0, 1197, 1200};
    tbl[2] = '{0, 0, 5, 5, 10, 10, 'h055, 0, 0, 0, -1, -1, -1};
    tbl[3] = '{390, 290, 450, 290, 390, 350, 'h1C3, 90, 90, 90, 116100, 119699, 119699};
    tbl[4] = '{5, 5, 6, 5, 5, 6, 'h00F, 3, 4, 3, 2000, 2399, 2400};
    tbl[5] = '{400, 10, 450, 10, 400, 50, 'h077, 0, 0, 0, -1, -1, -1};
    tbl[6] = '{10, 10, 14, 10, 10, 14, 'h123, 15, 25, 15, 4000, 5596, 5600};

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", pix_valid, 0);
    check("reset_addr", pix_addr, 0);
    check("reset_data", pix_data, 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Backpressure at the first write, with a stray start while scanning.
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (FILL || x + y <= 3) begin
          exp_a.push_back(y * FB_W + x);
          exp_d.push_back((x + y <= 3) ? 'h0A5 : 'h1FF);
        end
    pix_ready = 1'b0;
    start_tri(tbl[0]);
    begin
      int n = 0;
      while (!pix_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        x1 = XW'(20);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), pix_valid, 1);
      check($sformatf("bp_addr_%0d", k), pix_addr, 0);
      check($sformatf("bp_data_%0d", k), pix_data, 'h0A5);
      check($sformatf("bp_busy_%0d", k), busy, 1);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    wait_done("bp");
    check("bp_count", wr_addr.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < wr_addr.size(); k++) begin
      check($sformatf("bp_seq_addr_%0d", k), wr_addr[k], exp_a[k]);
      check($sformatf("bp_seq_data_%0d", k), wr_data[k], exp_d[k]);
    end

    // Reset in the middle of a scan aborts silently; the next draw is normal.
    start_tri(tbl[6]);
    begin
      int n = 0;
      while (wr_addr.size() < 3 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_mid_progress", wr_addr.size() >= 3, 1);
    @(posedge clk); #1;
    done_cnt = 0;
    reset = 1'b0;
    #1;
    check("rst_mid_valid", pix_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle_busy", busy, 0);
    run_vec(tbl[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_raster_stream.md
Name: tri_raster_stream

Overview:
- Parametrised triangle rasterizer feeding the frame-buffer write port.
- Latches three vertices and a colour on start, then scans the clamped bounding box row-major using incremental edge functions.
- Emits one pixel write per inside pixel over a valid/ready stream.
- Successor to the fixed-vertex triangle drawer: runtime vertices, any winding, clipping, degenerate detection, backpressure, start/done handshake.

Parameters:
- FB_W, 399, frame width in pixels; also the address stride.
- FB_H, 300, frame height in pixels.
- XW, 9, vertex x width (unsigned).
- YW, 9, vertex y width (unsigned).
- COLOR_W, 9, pixel data width.
- ADDR_W, 17, pixel address width; must satisfy FB_W*FB_H <= 2^ADDR_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x0,x1,x2  in  XW each  vertex x coordinates.
- y0,y1,y2  in  YW each  vertex y coordinates.
- color  in  COLOR_W  fill colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the triangle is finished.
- pix_valid  out  1  pixel write pending.
- pix_ready  in  1  frame-buffer sink accepts the pixel.
- pix_addr  out  ADDR_W  y*FB_W + x.
- pix_data  out  COLOR_W  pixel colour.

Behaviour:
- Reset (async, active-low): state=IDLE; busy, done, pix_valid = 0; pix_addr, pix_data = 0. Reset asserted mid-scan aborts with no done pulse.
- IDLE: start=1 latches vertices and colour, goes to SETUP. start in any other state is ignored.
- SETUP (1 cycle):
  - bbox xmin/xmax/ymin/ymax = min/max of vertices, clamped to [0,FB_W-1] and [0,FB_H-1].
  - Per edge i (v0->v1, v1->v2, v2->v0): A_i = yb-ya, B_i = -(xb-xa).
  - area = E_01 evaluated at v2.
- INIT (1 cycle):
  - area==0 (degenerate) -> DONE with no pixels.
  - area<0 -> negate A, B and E for all edges, so either winding works.
  - Else evaluate E_i at (xmin,ymin); go to SCAN.
- Edge function: E(x,y) = A*(x-xa) + B*(y-ya). Arithmetic is signed, width max(XW,YW)*2+3, no overflow. Inside = all E_i >= 0 (edges inclusive).
- SCAN:
  - Current pixel inside: drive pix_valid=1, pix_addr, pix_data=color. Hold all three stable until pix_ready. Advance on the cycle pix_valid&&pix_ready.
  - Current pixel outside: advance in one cycle, pix_valid=0.
  - Advance in x: E_i += A_i.
  - At x==xmax: x=xmin, y+1, E reloaded from the row-start accumulator (row start += B_i).
  - After (xmax,ymax) is consumed -> DONE.
  - Sustained throughput is 1 pixel/cycle with pix_ready=1.
- DONE (1 cycle): done=1, busy=0 next cycle, then IDLE. A start in the DONE cycle is ignored.
- Latency: start at cycle T -> first possible pix_valid at T+3. Degenerate triangle -> done at T+3.
- Vertices entirely off-frame with an empty clamped bbox (min>max) are treated as degenerate.

Optional Feature:
- Macro BBOX_FILL_EN.
- Defined: outside pixels in the bbox are also emitted, with pix_data = all-ones (background), matching the legacy rectangle-fill output. The scan then always writes (xmax-xmin+1)*(ymax-ymin+1) pixels.
- Undefined: only inside pixels are emitted.

Test Plan:
- (0,0),(3,0),(0,3), color=0x0A5, pix_ready=1 -> exactly 10 writes. Addresses 0,1,2,3,399,400,401,798,799,1197 in order, all data 0x0A5. Then one done pulse.
- Same triangle with v1 and v2 swapped (opposite winding) -> identical 10 writes.
- Collinear (0,0),(5,5),(10,10) -> zero pix_valid, done exactly 3 cycles after start.
- First triangle with pix_ready held low 5 cycles at the first write -> pix_addr=0 and pix_data stable throughout, then the remaining sequence unchanged; start pulsed mid-scan is ignored.
- (390,290),(450,290),(390,350) -> no address >= 399*300. Max x = 398, max y = 299, first address 290*399+390=116100.
- Reset low during SCAN -> pix_valid, busy, done = 0 immediately, no done pulse. A new start after release draws normally. With BBOX_FILL_EN, the first test gives 16 writes: 6 with data 0x1FF, 10 with data 0x0A5.
